// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if
// Operation/result bus of the sequential ALU.
//   master : the issue side. It drives flush, in_valid, op, a, b and out_ready.
//   slave  : the execution unit. It drives in_ready, out_valid, result,
//            z/s/c/v and busy.
// ---------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             z;
    logic             s;
    logic             c;
    logic             v;
    logic             busy;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, z, s, c, v, busy
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, z, s, c, v, busy
    );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Handshaked execution unit. Base integer ops complete in one cycle. RV32M
// multiply/divide/remainder ops iterate for WIDTH cycles: shift-add for the
// multiplies, restoring division for divide and remainder.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_alu_if.slave. It carries:
//           - flush, the synchronous abort;
//           - the in_valid/in_ready handshake with op, a and b;
//           - the out_valid/out_ready handshake with result and z/s/c/v;
//           - busy.
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_PASS   = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_AND    = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLL    = 5'd8;
    localparam logic [4:0] OP_SLT    = 5'd9;
    localparam logic [4:0] OP_SLTU   = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   result_q;
    logic               z_q, s_q, c_q, v_q;
    logic [SHW-1:0]     count_q;
    logic [4:0]         op_q;
    // Multiply: {partial product high, multiplier/product low}.
    // Divide:   {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic               neg_q;      // product/quotient must be negated
    logic               rneg_q;     // remainder must be negated
    logic               dz_q;       // divisor was zero

    function automatic logic [1:0] zs_flags(input logic [WIDTH-1:0] r);
        return {(r == '0), r[WIDTH-1]};
    endfunction

    logic in_ready;
    logic accept;

    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.z         = z_q;
    assign bus.s         = s_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;

    // Single-cycle datapath.
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] alu_res_d;
    logic             alu_c_d;
    logic             alu_v_d;

    assign shamt = bus.b[SHW-1:0];

    always_comb begin
        add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
        // The top bit of a-b borrows exactly when a+~b+1 produces no carry.
        sub_diff  = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res_d = add_sum[WIDTH-1:0];
                alu_c_d   = add_sum[WIDTH];
                alu_v_d   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d = sub_diff[WIDTH-1:0];
                alu_c_d   = ~sub_diff[WIDTH];
                alu_v_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_PASS: alu_res_d = bus.b;
            OP_OR:   alu_res_d = bus.a | bus.b;
            OP_AND:  alu_res_d = bus.a & bus.b;
            OP_XOR:  alu_res_d = bus.a ^ bus.b;
            OP_SRL:  alu_res_d = bus.a >> shamt;
            OP_SRA:  alu_res_d = $unsigned($signed(bus.a) >>> shamt);
            OP_SLL:  alu_res_d = bus.a << shamt;
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: alu_res_d = '0;
        endcase
    end

    // The iterative ops work on magnitudes. The signs are restored at the end.
    logic             a_sgn, b_sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             is_mul, is_div;

    assign is_mul = (bus.op[4:2] == 3'b100);
    assign is_div = (bus.op[4:2] == 3'b101);

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (bus.op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            OP_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_sgn & bus.a[WIDTH-1];
    assign b_neg = b_sgn & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // One shift-add multiply step, plus the final sign fix-up and half select.
    logic [WIDTH:0]     mul_hi_sum;
    logic [2*WIDTH-1:0] mul_acc_nx;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_res;

    always_comb begin
        mul_hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        mul_acc_nx = {mul_hi_sum, acc_q[WIDTH-1:1]};
        mul_prod   = neg_q ? -mul_acc_nx : mul_acc_nx;
        mul_res    = (op_q == OP_MUL) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
    end

    // One restoring-division step, plus the final sign fix-up.
    // With a zero divisor every trial succeeds. That gives an all-ones quotient
    // and leaves the dividend as remainder. The quotient is then kept as all
    // ones, so it is not negated.
    logic [WIDTH:0]     div_rs;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_acc_nx;
    logic [WIDTH-1:0]   quo_fix, rem_fix, div_res;

    always_comb begin
        div_rs     = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial  = div_rs - {1'b0, opb_q};
        div_acc_nx = div_trial[WIDTH] ? {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        quo_fix    = (neg_q && !dz_q) ? -div_acc_nx[WIDTH-1:0] : div_acc_nx[WIDTH-1:0];
        rem_fix    = rneg_q ? -div_acc_nx[2*WIDTH-1:WIDTH] : div_acc_nx[2*WIDTH-1:WIDTH];
        div_res    = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_fix : rem_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
            s_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            count_q     <= '0;
            op_q        <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_q   <= mul_acc_nx;
                    count_q <= count_q + SHW'(1);
                    if (count_q == LAST_STEP) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        count_q     <= '0;
                        result_q    <= mul_res;
                        {z_q, s_q}  <= zs_flags(mul_res);
                        c_q         <= 1'b0;
                        v_q         <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc_q   <= div_acc_nx;
                    count_q <= count_q + SHW'(1);
                    if (count_q == LAST_STEP) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        count_q     <= '0;
                        result_q    <= div_res;
                        {z_q, s_q}  <= zs_flags(div_res);
                        c_q         <= 1'b0;
                        v_q         <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE. A result handoff and a new accept can
                    // happen in the same cycle. The accept branch wins.
                    if ((state_q == S_DONE) && bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        op_q    <= bus.op;
                        count_q <= '0;
                        if (is_mul || is_div) begin
                            acc_q       <= {{WIDTH{1'b0}}, a_mag};
                            opb_q       <= b_mag;
                            neg_q       <= a_neg ^ b_neg;
                            rneg_q      <= a_neg;
                            dz_q        <= (bus.b == '0);
                            state_q     <= is_mul ? S_MUL : S_DIV;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            result_q    <= alu_res_d;
                            {z_q, s_q}  <= zs_flags(alu_res_d);
                            c_q         <= alu_c_d;
                            v_q         <= alu_v_d;
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule
